// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN top-K selector.
package knn_pkg;

   localparam int DIST_W_DEF  = 32;
   localparam int LABEL_W_DEF = 4;

   localparam logic [DIST_W_DEF-1:0] DIST_EMPTY = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_RESULT
   } topk_state_t;

endpackage

// File: rtl/topk_slot.sv
// One sorted-list entry: holds, shifts from the previous slot, or loads the
// incoming sample depending on its own and its predecessor's less-than flag.
module topk_slot
   import knn_pkg::*;
#(
   parameter int DIST_W  = DIST_W_DEF,
   parameter int LABEL_W = LABEL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clear,
   input  logic               i_en,
   input  logic [DIST_W-1:0]  i_dist,
   input  logic [LABEL_W-1:0] i_label,
   input  logic               i_prev_lt,
   input  logic [DIST_W-1:0]  i_prev_dist,
   input  logic [LABEL_W-1:0] i_prev_label,
   output logic               o_lt,
   output logic [DIST_W-1:0]  o_dist,
   output logic [LABEL_W-1:0] o_label
);

   logic [DIST_W-1:0]  r_dist;
   logic [LABEL_W-1:0] r_label;

   // Strict compare keeps ties stable and never admits an all-ones sample.
   assign o_lt    = i_dist < r_dist;
   assign o_dist  = r_dist;
   assign o_label = r_label;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dist  <= '1;
         r_label <= '0;
      end else if (i_clear) begin
         r_dist  <= '1;
         r_label <= '0;
      end else if (i_en && o_lt) begin
         if (i_prev_lt) begin
            r_dist  <= i_prev_dist;
            r_label <= i_prev_label;
         end else begin
            r_dist  <= i_dist;
            r_label <= i_label;
         end
      end
   end

endmodule

// File: rtl/knn_topk_sorter.sv
// Streaming top-K selector: keeps the K smallest distances of a query in
// ascending order and hands the list to the voting stage.
module knn_topk_sorter
   import knn_pkg::*;
#(
   parameter int K       = 5,
   parameter int DIST_W  = DIST_W_DEF,
   parameter int LABEL_W = LABEL_W_DEF,
   localparam int CNT_W  = $clog2(K+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DIST_W-1:0]    in_dist,
   input  logic [LABEL_W-1:0]   in_label,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [K*DIST_W-1:0]  out_dist,
   output logic [K*LABEL_W-1:0] out_label,
   output logic [CNT_W-1:0]     out_count
);

   topk_state_t r_state;
   topk_state_t w_next;
   logic [CNT_W-1:0] r_count;

   logic               w_clear;
   logic               w_accept;
   logic               w_insert;
   logic [K-1:0]       w_lt;
   logic [DIST_W-1:0]  w_dist  [K];
   logic [LABEL_W-1:0] w_label [K];

   assign in_ready  = (r_state == S_COLLECT);
   assign out_valid = (r_state == S_RESULT);
   assign out_count = r_count;

   assign w_clear  = (r_state == S_IDLE) && start;
   assign w_accept = in_valid && in_ready;
   // Flags form a thermometer over an ascending list, so any flag means insert.
   assign w_insert = w_accept && (|w_lt);

   for (genvar g = 0; g < K; g++) begin : g_slot
      logic               w_prev_lt;
      logic [DIST_W-1:0]  w_prev_dist;
      logic [LABEL_W-1:0] w_prev_label;

      if (g == 0) begin : g_head
         assign w_prev_lt    = 1'b0;
         assign w_prev_dist  = '0;
         assign w_prev_label = '0;
      end else begin : g_body
         assign w_prev_lt    = w_lt[g-1];
         assign w_prev_dist  = w_dist[g-1];
         assign w_prev_label = w_label[g-1];
      end

      topk_slot #(
         .DIST_W  (DIST_W),
         .LABEL_W (LABEL_W)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .i_clear      (w_clear),
         .i_en         (w_accept),
         .i_dist       (in_dist),
         .i_label      (in_label),
         .i_prev_lt    (w_prev_lt),
         .i_prev_dist  (w_prev_dist),
         .i_prev_label (w_prev_label),
         .o_lt         (w_lt[g]),
         .o_dist       (w_dist[g]),
         .o_label      (w_label[g])
      );

      assign out_dist[g*DIST_W +: DIST_W]    = w_dist[g];
      assign out_label[g*LABEL_W +: LABEL_W] = w_label[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (start) w_next = S_COLLECT;
         S_COLLECT: if (w_accept && in_last) w_next = S_RESULT;
         S_RESULT:  if (out_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_clear) begin
         r_count <= '0;
      end else if (w_insert && (r_count < CNT_W'(K))) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Directed bench for knn_topk_sorter with K=4.
module tb_knn_topk_sorter;

   localparam int K       = 4;
   localparam int DIST_W  = 32;
   localparam int LABEL_W = 4;
   localparam int CNT_W   = $clog2(K+1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DIST_W-1:0]    in_dist = '0;
   logic [LABEL_W-1:0]   in_label = '0;
   logic                 in_last = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [K*DIST_W-1:0]  out_dist;
   logic [K*LABEL_W-1:0] out_label;
   logic [CNT_W-1:0]     out_count;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [DIST_W-1:0] E = '1;

   logic [K*DIST_W-1:0]  hold_dist;
   logic [K*LABEL_W-1:0] hold_label;

   knn_topk_sorter #(
      .K       (K),
      .DIST_W  (DIST_W),
      .LABEL_W (LABEL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dist   (in_dist),
      .in_label  (in_label),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dist  (out_dist),
      .out_label (out_label),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [DIST_W-1:0] d, input logic [LABEL_W-1:0] l,
                       input logic last);
      in_valid = 1'b1;
      in_dist  = d;
      in_label = l;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_in_ready",  {127'd0, in_ready}, 128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_count",     {125'd0, out_count}, 128'd0);
      chk("rst_dist",      out_dist, {E, E, E, E});
      chk("rst_label",     {112'd0, out_label}, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic ordering
      do_start();
      chk("t1_in_ready", {127'd0, in_ready}, 128'd1);
      send(32'd50, 4'd1, 1'b0);
      send(32'd20, 4'd2, 1'b0);
      send(32'd70, 4'd3, 1'b0);
      in_valid = 1'b1; in_dist = 32'd10; in_label = 4'd4; in_last = 1'b1;
      chk("t1_valid_before", {127'd0, out_valid}, 128'd0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("t1_out_valid", {127'd0, out_valid}, 128'd1);
      chk("t1_in_ready_low", {127'd0, in_ready}, 128'd0);
      chk("t1_dist",  out_dist, {32'd70, 32'd50, 32'd20, 32'd10});
      chk("t1_label", {112'd0, out_label}, {112'd0, 4'd3, 4'd1, 4'd2, 4'd4});
      chk("t1_count", {125'd0, out_count}, 128'd4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t1_idle_valid", {127'd0, out_valid}, 128'd0);
      chk("t1_idle_ready", {127'd0, in_ready}, 128'd0);

      // back-to-back descending stream
      do_start();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_dist  = DIST_W'(9 - i);
         in_label = LABEL_W'(i + 1);
         in_last  = (i == 7);
         chk($sformatf("t2_ready_%0d", i), {127'd0, in_ready}, 128'd1);
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("t2_dist",  out_dist, {32'd5, 32'd4, 32'd3, 32'd2});
      chk("t2_label", {112'd0, out_label}, {112'd0, 4'd5, 4'd6, 4'd7, 4'd8});
      chk("t2_count", {125'd0, out_count}, 128'd4);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // stable ties
      do_start();
      send(32'd30, 4'd1, 1'b0);
      send(32'd30, 4'd2, 1'b0);
      send(32'd10, 4'd3, 1'b0);
      send(32'd30, 4'd4, 1'b1);
      chk("t3_dist",  out_dist, {32'd30, 32'd30, 32'd30, 32'd10});
      chk("t3_label", {112'd0, out_label}, {112'd0, 4'd4, 4'd2, 4'd1, 4'd3});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // partial fill plus an all-ones sample that must be dropped
      do_start();
      send(E, 4'd7, 1'b0);
      chk("t4_ones_count", {125'd0, out_count}, 128'd0);
      chk("t4_ones_dist",  out_dist, {E, E, E, E});
      send(32'd40, 4'd5, 1'b0);
      send(32'd15, 4'd6, 1'b1);
      chk("t4_count", {125'd0, out_count}, 128'd2);
      chk("t4_dist",  out_dist, {E, E, 32'd40, 32'd15});
      chk("t4_label", {112'd0, out_label}, {112'd0, 4'd0, 4'd0, 4'd5, 4'd6});

      // hold in RESULT with stray start / in_valid pulses
      hold_dist  = out_dist;
      hold_label = out_label;
      for (int i = 0; i < 5; i++) begin
         start    = (i == 1);
         in_valid = (i == 2) || (i == 3);
         in_dist  = 32'd1;
         in_label = 4'd9;
         in_last  = 1'b1;
         @(negedge clk);
         chk($sformatf("t5_valid_%0d", i), {127'd0, out_valid}, 128'd1);
         chk($sformatf("t5_dist_%0d", i), out_dist, {E, E, 32'd40, 32'd15});
         chk($sformatf("t5_count_%0d", i), {125'd0, out_count}, 128'd2);
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      chk("t5_label", {112'd0, out_label}, {112'd0, 4'd0, 4'd0, 4'd5, 4'd6});
      out_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      chk("t5_idle_valid", {127'd0, out_valid}, 128'd0);
      chk("t5_start_ignored", {127'd0, in_ready}, 128'd0);
      @(negedge clk);
      chk("t5_still_idle", {127'd0, in_ready}, 128'd0);
      chk("t5_list_kept", out_dist, {E, E, 32'd40, 32'd15});

      // asynchronous reset mid-collect
      do_start();
      send(32'd7, 4'd1, 1'b0);
      send(32'd8, 4'd2, 1'b0);
      send(32'd9, 4'd3, 1'b0);
      chk("t6_pre_count", {125'd0, out_count}, 128'd3);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_ready", {127'd0, in_ready}, 128'd0);
      chk("t6_rst_count", {125'd0, out_count}, 128'd0);
      chk("t6_rst_dist",  out_dist, {E, E, E, E});
      chk("t6_rst_label", {112'd0, out_label}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_start();
      send(32'd5, 4'd2, 1'b1);
      chk("t6_valid", {127'd0, out_valid}, 128'd1);
      chk("t6_dist0", {96'd0, out_dist[31:0]}, 128'd5);
      chk("t6_count", {125'd0, out_count}, 128'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
